vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with a pipelined pixel-fetch interface. It is the generalised successor to the fixed 640x480, 4-bit-per-channel scan-line display driver. It drives timing for any mode, including 800x600@60 Hz at a 40 MHz pixel clock. Pixels are requested by (x, y) coordinate a fixed number of cycles ahead instead of being read from a full scan-line bus, and missing data is flagged as underflow.

---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Pixels are requested by (x, y)
// FETCH_LATENCY cycles ahead; missing data shows UNDERFLOW_RGB and sets a sticky flag.
module vga_timing_gen #(
   parameter int PIXEL_DEPTH   = 4,
   parameter int H_ACTIVE      = 800,
   parameter int H_FRONT       = 40,
   parameter int H_SYNC        = 128,
   parameter int H_BACK        = 88,
   parameter int V_ACTIVE      = 600,
   parameter int V_FRONT       = 1,
   parameter int V_SYNC        = 4,
   parameter int V_BACK        = 23,
   parameter logic H_SYNC_POL  = 1'b1,
   parameter logic V_SYNC_POL  = 1'b1,
   parameter int FETCH_LATENCY = 2,
   parameter int CNT_W         = 11,
   parameter logic [3*PIXEL_DEPTH-1:0] UNDERFLOW_RGB = '0
) (
   input  logic                     clock_pixel,
   input  logic                     reset,
   output logic                     pixel_req,
   output logic [CNT_W-1:0]         pixel_x,
   output logic [CNT_W-1:0]         pixel_y,
   output logic                     frame_start,
   output logic                     line_start,
   input  logic [3*PIXEL_DEPTH-1:0] pixel_rgb,
   input  logic                     pixel_valid,
   output logic [PIXEL_DEPTH-1:0]   red,
   output logic [PIXEL_DEPTH-1:0]   green,
   output logic [PIXEL_DEPTH-1:0]   blue,
   output logic                     h_sync,
   output logic                     v_sync,
   output logic                     active_video,
   output logic                     underflow,
   input  logic                     underflow_clr
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   // Each delay stage holds {active, h_sync asserted, v_sync asserted}.
   logic [FETCH_LATENCY-1:0][2:0] dly_q, dly_d;
   logic [2:0] tap;
   logic hs_now, vs_now;
   logic [3*PIXEL_DEPTH-1:0] rgb_sel;
   logic [PIXEL_DEPTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic hs_q, hs_d, vs_q, vs_d, act_q, act_d;
   logic uf_evt_q, uf_evt_d, underflow_q, underflow_d;

   always_comb begin
      h_d = h_q + CNT_W'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end
   end

   always_comb begin
      pixel_req   = (h_q < H_ACT) && (v_q < V_ACT);
      pixel_x     = pixel_req ? h_q : '0;
      pixel_y     = pixel_req ? v_q : '0;
      frame_start = (h_q == '0) && (v_q == '0);
      line_start  = pixel_req && (h_q == '0);
      hs_now      = (h_q >= H_SS) && (h_q < H_SE);
      vs_now      = (v_q >= V_SS) && (v_q < V_SE);
   end

   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = {pixel_req, hs_now, vs_now};
      for (int i = 1; i < FETCH_LATENCY; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   // The requested pixel is due on the cycle its flags leave the delay line.
   always_comb begin
      tap      = dly_q[FETCH_LATENCY-1];
      act_d    = tap[2];
      hs_d     = tap[1] ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d     = tap[0] ? V_SYNC_POL : ~V_SYNC_POL;
      uf_evt_d = tap[2] & ~pixel_valid;
      rgb_sel  = '0;
      if (tap[2]) begin
         rgb_sel = pixel_valid ? pixel_rgb : UNDERFLOW_RGB;
      end
      red_d   = rgb_sel[PIXEL_DEPTH-1:0];
      green_d = rgb_sel[2*PIXEL_DEPTH-1:PIXEL_DEPTH];
      blue_d  = rgb_sel[3*PIXEL_DEPTH-1:2*PIXEL_DEPTH];
      // A new underflow outranks a simultaneous clear.
      underflow_d = uf_evt_q | (underflow_q & ~underflow_clr);
   end

   always_ff @(posedge clock_pixel) begin
      if (reset) begin
         h_q         <= '0;
         v_q         <= '0;
         dly_q       <= '0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         hs_q        <= ~H_SYNC_POL;
         vs_q        <= ~V_SYNC_POL;
         act_q       <= 1'b0;
         uf_evt_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         dly_q       <= dly_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         act_q       <= act_d;
         uf_evt_q    <= uf_evt_d;
         underflow_q <= underflow_d;
      end
   end

   assign red          = red_q;
   assign green        = green_q;
   assign blue         = blue_q;
   assign h_sync       = hs_q;
   assign v_sync       = vs_q;
   assign active_video = act_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small mode with a raster model and expected-output
// queue, plus a default 800x600 instance with active-low h_sync.
module tb_vga_timing_gen;
   localparam int HA = 8, HF = 2, HS = 3, HB = 1;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [11:0] UF_RGB = 12'h5A3;
   localparam logic HPOL = 1'b1, VPOL = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic underflow_clr = 1'b0;
   logic [11:0] pixel_rgb = '0;
   logic pixel_valid = 1'b0;
   logic pixel_req, frame_start, line_start;
   logic [10:0] pixel_x, pixel_y;
   logic [3:0] red, green, blue;
   logic h_sync, v_sync, active_video, underflow;

   logic big_reset = 1'b1;
   logic b_req, b_fs, b_ls, b_hs, b_vs, b_act, b_uf;
   logic [10:0] b_x, b_y;
   logic [3:0] b_r, b_g, b_b;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .FETCH_LATENCY(2), .UNDERFLOW_RGB(UF_RGB)
   ) u_dut (
      .clock_pixel(clk), .reset(reset), .pixel_req(pixel_req),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
      .line_start(line_start), .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid),
      .red(red), .green(green), .blue(blue), .h_sync(h_sync), .v_sync(v_sync),
      .active_video(active_video), .underflow(underflow), .underflow_clr(underflow_clr)
   );

   vga_timing_gen #(.H_SYNC_POL(1'b0)) u_big (
      .clock_pixel(clk), .reset(big_reset), .pixel_req(b_req),
      .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs), .line_start(b_ls),
      .pixel_rgb(12'h000), .pixel_valid(1'b1),
      .red(b_r), .green(b_g), .blue(b_b), .h_sync(b_hs), .v_sync(b_vs),
      .active_video(b_act), .underflow(b_uf), .underflow_clr(1'b0)
   );

   typedef struct packed {
      logic act, hs, vs;
      logic [3:0] r, g, b;
      logic uf;
   } exp_t;

   typedef struct packed {
      logic req;
      logic [10:0] x, y;
      logic drop;
   } rec_t;

   exp_t exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   logic small_done = 1'b0;
   logic exp_uf, last_evt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e = '0;
      e.hs = ~HPOL;
      e.vs = ~VPOL;
      return e;
   endfunction

   // Expected pins for the raster position reached n cycles after reset release.
   function automatic exp_t model_out(input int n, input logic drop);
      exp_t e;
      int h, v;
      logic [11:0] ufc;
      ufc = UF_RGB;
      h = n % HT;
      v = (n / HT) % VT;
      e = blank();
      e.act = (h < HA) && (v < VA);
      e.hs = ((h >= HA + HF) && (h < HA + HF + HS)) ? HPOL : ~HPOL;
      e.vs = ((v >= VA + VF) && (v < VA + VF + VS)) ? VPOL : ~VPOL;
      if (e.act && drop) begin
         e.r = ufc[3:0];
         e.g = ufc[7:4];
         e.b = ufc[11:8];
         e.uf = 1'b1;
      end else if (e.act) begin
         e.r = 4'(h);
         e.g = 4'(v);
         e.b = 4'hF;
      end
      return e;
   endfunction

   task automatic run_small();
      int n = 0;
      int phase = 0;
      int h, v;
      logic act, drop, clr, rst_next;
      rec_t rec1, rec2, cur;
      rec1 = '0;
      rec2 = '0;
      for (int t = 0; t < 3300; t++) begin
         @(negedge clk);
         if (reset) n = 0;
         else n++;
         h = n % HT;
         v = (n / HT) % VT;
         act = (h < HA) && (v < VA);
         check("pixel_req", 32'(pixel_req), 32'(act));
         check("pixel_x", 32'(pixel_x), act ? h : 0);
         check("pixel_y", 32'(pixel_y), act ? v : 0);
         check("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
         check("line_start", 32'(line_start), 32'(act && (h == 0)));
         if (rec2.req) begin
            pixel_valid = ~rec2.drop;
            pixel_rgb = rec2.drop ? 12'($urandom) : {4'hF, rec2.y[3:0], rec2.x[3:0]};
         end else begin
            pixel_valid = 1'($urandom);
            pixel_rgb = 12'($urandom);
         end
         if (t < 2) begin
            rst_next = 1'b1; drop = 1'b0; clr = 1'b0;
         end else if (phase == 0) begin
            drop = (n == 33) || (n == 44);
            clr = (n == 40) || (n == 47);
            rst_next = (n == 160);
            if (rst_next) phase = 1;
         end else begin
            drop = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 15) == 0);
            rst_next = ($urandom_range(0, 299) == 0);
         end
         cur.req = pixel_req;
         cur.x = pixel_x;
         cur.y = pixel_y;
         cur.drop = drop;
         rec2 = rec1;
         rec1 = cur;
         reset = rst_next;
         underflow_clr = clr;
         if (rst_next) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(blank());
         end else begin
            exp_q.push_back(model_out(n, drop));
         end
      end
      small_done = 1'b1;
   endtask

   task automatic run_big();
      int h, v, hl, lows;
      logic exp_hs;
      lows = 0;
      repeat (2) @(negedge clk);
      big_reset = 1'b0;
      for (int n = 0; n < 3 * 1056 + 3; n++) begin
         if (n > 0) @(negedge clk);
         h = n % 1056;
         v = n / 1056;
         check("big_pixel_req", 32'(b_req), 32'((h < 800) && (v < 600)));
         check("big_frame_start", 32'(b_fs), 32'(n == 0));
         if (n < 3) exp_hs = 1'b1;
         else begin
            hl = (n - 3) % 1056;
            exp_hs = !((hl >= 840) && (hl < 968));
         end
         check("big_h_sync", 32'(b_hs), 32'(exp_hs));
         check("big_v_sync", 32'(b_vs), 32'(0));
         if (n >= 3 && b_hs == 1'b0) lows++;
      end
      check("big_h_sync_low_count", lows, 384);
   endtask

   initial begin
      exp_t e;
      @(negedge clk);
      while (!small_done) begin
         @(posedge clk);
         #2;
         if (small_done) break;
         if (reset) begin
            exp_uf = 1'b0;
            last_evt = 1'b0;
         end else begin
            exp_uf = last_evt | (exp_uf & ~underflow_clr);
         end
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q: no expected entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("active_video", 32'(active_video), 32'(e.act));
            check("h_sync", 32'(h_sync), 32'(e.hs));
            check("v_sync", 32'(v_sync), 32'(e.vs));
            check("rgb", 32'({blue, green, red}), 32'({e.b, e.g, e.r}));
            last_evt = e.uf;
         end
         check("underflow", 32'(underflow), 32'(exp_uf));
      end
   end

   initial begin
      fork
         run_small();
         run_big();
      join
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
